rom_region_loader: RTL and testbench

ROM_REGION_LOADER -- requirements
Module: rom_region_loader

---
 rtl/rom_region_loader.sv | 274 +++++++++++++++++++++++++++
 tb/tb_rom_region_loader.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_region_loader.sv
// Download-stream region loader.
// Parses a byte stream of {index, 32-bit LE length, data...} records and turns
// the data bytes into 16-bit little-endian storage writes at the base address
// of the selected load region. An index of 0xFF terminates the stream.

package sys_pkg;
    localparam logic [3:0] STOR_SDR   = 4'h1;
    localparam logic [3:0] STOR_DDR   = 4'h2;
    localparam logic [3:0] STOR_BLOCK = 4'h4;

    typedef struct packed {
        logic [31:0] base_addr;
        logic [3:0]  storage;
    } load_region_t;

    localparam int LOAD_REGION_COUNT = 9;

    localparam load_region_t LOAD_REGIONS [LOAD_REGION_COUNT] = '{
        '{base_addr: 32'h0000_0000, storage: STOR_SDR},
        '{base_addr: 32'h0090_0000, storage: STOR_SDR},
        '{base_addr: 32'h3810_0000, storage: STOR_DDR},
        '{base_addr: 32'h0010_0000, storage: STOR_BLOCK},
        '{base_addr: 32'h0100_0000, storage: STOR_SDR},
        '{base_addr: 32'h3800_0000, storage: STOR_DDR},
        '{base_addr: 32'h0020_0000, storage: STOR_BLOCK},
        '{base_addr: 32'h0200_0000, storage: STOR_SDR},
        '{base_addr: 32'hFFFF_FFF0, storage: STOR_DDR}
    };
endpackage

module rom_region_loader #(
    parameter int NUM_REGIONS = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    output logic        wr_req,
    output logic [3:0]  wr_storage,
    output logic [31:0] wr_addr,
    output logic [15:0] wr_data,
    output logic [1:0]  wr_be,
    input  logic        wr_ack,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR_IDX = 3'd1,
        S_HDR_LEN = 3'd2,
        S_DATA    = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_e;

    localparam logic [8:0] NUM_REGIONS_W = 9'(NUM_REGIONS);

    state_e r_state;
    state_e w_state_nxt;

    logic        r_act_d;
    logic [31:0] r_base;
    logic [3:0]  r_class;
    logic [31:0] r_len;
    logic [1:0]  r_len_cnt;
    logic [31:0] r_off;
    logic [7:0]  r_lo;
    logic        r_wr_req;
    logic [3:0]  r_wr_storage;
    logic [31:0] r_wr_addr;
    logic [15:0] r_wr_data;
    logic [1:0]  r_wr_be;
    logic        r_done;
    logic        r_error;

    logic        w_rise;
    logic        w_fall;
    logic        w_byte;
    logic        w_busy_wr;
    logic        w_last;
    logic        w_emit;
    logic        w_take_idx;
    logic        w_take_len;
    logic        w_take_data;
    logic [31:0] w_len_full;
    sys_pkg::load_region_t w_region;

    // Table lookup that returns zero for indices outside the shared table.
    function automatic sys_pkg::load_region_t region_lookup(input logic [7:0] idx);
        sys_pkg::load_region_t r;
        r = '0;
        for (int i = 0; i < sys_pkg::LOAD_REGION_COUNT; i++) begin
            if (idx == 8'(i)) begin
                r = sys_pkg::LOAD_REGIONS[i];
            end
        end
        return r;
    endfunction

    // r_act_d resets high so a dl_active already high at release is not a rise.
    assign w_rise      = dl_active & ~r_act_d;
    assign w_fall      = ~dl_active & r_act_d;
    assign w_busy_wr   = dl_wr & r_wr_req;
    assign w_byte      = dl_wr & ~r_wr_req;
    assign w_last      = (r_off == (r_len - 32'd1));
    assign w_len_full  = {dl_data, r_len[31:8]};
    assign w_region    = region_lookup(dl_data);
    assign w_emit      = w_take_data & (r_off[0] | w_last);

    assign dl_wait    = r_wr_req;
    assign wr_req     = r_wr_req;
    assign wr_storage = r_wr_storage;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign wr_be      = r_wr_be;
    assign done       = r_done;
    assign error      = r_error;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: session edges first, then byte handling per state.
    always_comb begin
        w_state_nxt = r_state;
        w_take_idx  = 1'b0;
        w_take_len  = 1'b0;
        w_take_data = 1'b0;
        if (w_rise) begin
            w_state_nxt = S_HDR_IDX;
        end else if (w_fall && (r_state != S_IDLE)) begin
            if ((r_state == S_HDR_IDX) || (r_state == S_DONE)) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = S_ERROR;
            end
        end else begin
            case (r_state)
                S_HDR_IDX: begin
                    if (w_busy_wr) begin
                        w_state_nxt = S_ERROR;
                    end else if (w_byte) begin
                        if (dl_data == 8'hFF) begin
                            w_state_nxt = S_DONE;
                        end else if ({1'b0, dl_data} < NUM_REGIONS_W) begin
                            w_state_nxt = S_HDR_LEN;
                            w_take_idx  = 1'b1;
                        end else begin
                            w_state_nxt = S_ERROR;
                        end
                    end
                end
                S_HDR_LEN: begin
                    if (w_busy_wr) begin
                        w_state_nxt = S_ERROR;
                    end else if (w_byte) begin
                        w_take_len = 1'b1;
                        if (r_len_cnt == 2'd3) begin
                            w_state_nxt = (w_len_full == 32'd0) ? S_HDR_IDX : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_busy_wr) begin
                        w_state_nxt = S_ERROR;
                    end else if (w_byte) begin
                        w_take_data = 1'b1;
                        if (w_last) begin
                            w_state_nxt = S_HDR_IDX;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // dl_active history for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_act_d <= 1'b1;
        end else begin
            r_act_d <= dl_active;
        end
    end

    // Record header capture, offset counting and low-byte latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base    <= '0;
            r_class   <= '0;
            r_len     <= '0;
            r_len_cnt <= '0;
            r_off     <= '0;
            r_lo      <= '0;
        end else if (w_rise) begin
            r_len     <= '0;
            r_len_cnt <= '0;
            r_off     <= '0;
            r_lo      <= '0;
        end else begin
            if (w_take_idx) begin
                r_base    <= w_region.base_addr;
                r_class   <= w_region.storage;
                r_len     <= '0;
                r_len_cnt <= '0;
                r_off     <= '0;
            end
            if (w_take_len) begin
                r_len     <= w_len_full;
                r_len_cnt <= r_len_cnt + 2'd1;
            end
            if (w_take_data) begin
                r_off <= r_off + 32'd1;
                if (!r_off[0]) begin
                    r_lo <= dl_data;
                end
            end
        end
    end

    // Storage write port: load on a completing byte, hold until acknowledged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_req     <= 1'b0;
            r_wr_storage <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_be      <= '0;
        end else if (w_emit) begin
            r_wr_req     <= 1'b1;
            r_wr_storage <= r_class;
            if (r_off[0]) begin
                r_wr_addr <= r_base + r_off - 32'd1;
                r_wr_data <= {dl_data, r_lo};
                r_wr_be   <= 2'b11;
            end else begin
                r_wr_addr <= r_base + r_off;
                r_wr_data <= {8'h00, dl_data};
                r_wr_be   <= 2'b01;
            end
        end else if (r_wr_req && wr_ack) begin
            r_wr_req <= 1'b0;
        end
    end

    // Sticky completion flags, cleared when a new session starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else if (w_rise) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (w_state_nxt == S_DONE) begin
                r_done <= 1'b1;
            end
            if (w_state_nxt == S_ERROR) begin
                r_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_region_loader.sv
// Testbench for rom_region_loader: directed scenarios plus randomized
// record streams compared against a list-of-writes reference model.

module tb_rom_region_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dl_active;
    logic        dl_wr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic        wr_req;
    logic [3:0]  wr_storage;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        wr_ack = 1'b0;
    logic        done;
    logic        error;

    typedef struct packed {
        logic [3:0]  st;
        logic [31:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_t;

    typedef logic [7:0] bq_t[$];

    wr_t exp_q[$];
    wr_t obs_q[$];
    bq_t cur_q;
    int  tests = 0;
    int  fails = 0;
    int  ack_delay = 1;
    int  ack_cnt = 0;

    always #5 clk = ~clk;

    rom_region_loader #(.NUM_REGIONS(9)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_data    (dl_data),
        .dl_wait    (dl_wait),
        .wr_req     (wr_req),
        .wr_storage (wr_storage),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .wr_ack     (wr_ack),
        .done       (done),
        .error      (error)
    );

    // Storage arbiter: acknowledges a pending write after ack_delay cycles
    // and records the write it accepts.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (wr_req === 1'b1 && wr_ack === 1'b0) begin
                if (ack_cnt >= ack_delay) begin
                    w.st   = wr_storage;
                    w.addr = wr_addr;
                    w.data = wr_data;
                    w.be   = wr_be;
                    obs_q.push_back(w);
                    wr_ack  = 1'b1;
                    ack_cnt = 0;
                end else begin
                    ack_cnt++;
                end
            end else begin
                wr_ack  = 1'b0;
                ack_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill(input int n, input logic [31:0] v);
        cur_q.delete();
        for (int i = 0; i < n; i++) cur_q.push_back(v[8*i +: 8]);
    endtask

    task automatic fill_random(input int n);
        cur_q.delete();
        for (int i = 0; i < n; i++) cur_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        while (dl_wait === 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("dl_wait_release", {63'd0, dl_wait}, 64'd0);
        dl_wr   = 1'b1;
        dl_data = b;
        @(negedge clk);
        dl_wr   = 1'b0;
    endtask

    task automatic send_record(input logic [7:0] idx, input bq_t d);
        logic [31:0] n;
        n = 32'(d.size());
        send_byte(idx);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
        for (int i = 0; i < d.size(); i++) send_byte(d[i]);
    endtask

    task automatic push_exp(input logic [3:0] st, input logic [31:0] addr,
                            input logic [15:0] data, input logic [1:0] be);
        wr_t w;
        w.st = st; w.addr = addr; w.data = data; w.be = be;
        exp_q.push_back(w);
    endtask

    // Reference: a region's bytes map to consecutive LE halfwords from its base;
    // a trailing odd byte becomes a low-byte-only write.
    task automatic model_record(input int idx, input bq_t d);
        sys_pkg::load_region_t r;
        r = sys_pkg::LOAD_REGIONS[idx];
        for (int i = 0; i < d.size(); i += 2) begin
            if (i + 1 < d.size())
                push_exp(r.storage, r.base_addr + 32'(i), {d[i+1], d[i]}, 2'b11);
            else
                push_exp(r.storage, r.base_addr + 32'(i), {8'h00, d[i]}, 2'b01);
        end
    endtask

    task automatic drain_and_compare(input string tag);
        int guard;
        guard = 0;
        while ((wr_req === 1'b1 || obs_q.size() < exp_q.size()) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("%s_count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic start_session();
        dl_active = 1'b0;
        @(negedge clk);
        dl_active = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_session();
        dl_active = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int nrec;
        int idx;
        int len;

        reset_n   = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_data   = 8'h00;
        tick(2);

        // Reset values
        check("rst_wr_req", {63'd0, wr_req}, 64'd0);
        check("rst_dl_wait", {63'd0, dl_wait}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        check("rst_addr", {32'd0, wr_addr}, 64'd0);
        check("rst_data", {48'd0, wr_data}, 64'd0);
        check("rst_be", {62'd0, wr_be}, 64'd0);

        // dl_active already high at reset release is not a session start
        dl_active = 1'b1;
        tick(1);
        reset_n = 1'b1;
        tick(1);
        fill(2, 32'h0000_2211);
        send_record(8'h01, cur_q);
        send_byte(8'hFF);
        tick(3);
        drain_and_compare("no_rise_after_rst");
        check("no_rise_done", {63'd0, done}, 64'd0);
        check("no_rise_error", {63'd0, error}, 64'd0);

        // Region 1, four bytes, terminator
        ack_delay = 1;
        start_session();
        fill(4, 32'h4433_2211);
        send_record(8'h01, cur_q);
        push_exp(sys_pkg::STOR_SDR, 32'h0090_0000, 16'h2211, 2'b11);
        push_exp(sys_pkg::STOR_SDR, 32'h0090_0002, 16'h4433, 2'b11);
        send_byte(8'hFF);
        check("r1_done", {63'd0, done}, 64'd1);
        check("r1_error", {63'd0, error}, 64'd0);
        drain_and_compare("r1");
        end_session();
        tick(1);
        check("r1_done_sticky", {63'd0, done}, 64'd1);

        // Region 2, odd length
        start_session();
        check("r2_done_cleared", {63'd0, done}, 64'd0);
        fill(3, 32'h00CC_BBAA);
        send_record(8'h02, cur_q);
        push_exp(sys_pkg::STOR_DDR, 32'h3810_0000, 16'hBBAA, 2'b11);
        push_exp(sys_pkg::STOR_DDR, 32'h3810_0002, 16'h00CC, 2'b01);
        send_byte(8'hFF);
        check("r2_done", {63'd0, done}, 64'd1);
        drain_and_compare("r2");
        end_session();

        // Acknowledge stalled 10 cycles; a byte injected mid-stall
        ack_delay = 10;
        start_session();
        fill(2, 32'h0000_6655);
        send_record(8'h01, cur_q);
        push_exp(sys_pkg::STOR_SDR, 32'h0090_0000, 16'h6655, 2'b11);
        for (int k = 0; k < 10; k++) begin
            check("stall_req", {63'd0, wr_req}, 64'd1);
            check("stall_wait", {63'd0, dl_wait}, 64'd1);
            check("stall_addr", {32'd0, wr_addr}, 64'h0090_0000);
            check("stall_data", {48'd0, wr_data}, 64'h6655);
            check("stall_be", {62'd0, wr_be}, 64'd3);
            dl_data = 8'h77;
            dl_wr   = (k == 3);
            @(negedge clk);
        end
        dl_wr = 1'b0;
        drain_and_compare("stall");
        check("stall_error", {63'd0, error}, 64'd1);
        check("stall_done", {63'd0, done}, 64'd0);
        end_session();
        ack_delay = 1;

        // Out-of-range index
        start_session();
        send_byte(8'h09);
        check("badidx_error", {63'd0, error}, 64'd1);
        check("badidx_done", {63'd0, done}, 64'd0);
        fill(2, 32'h0000_0201);
        send_record(8'h01, cur_q);
        tick(3);
        drain_and_compare("badidx_ignored");
        check("badidx_error_sticky", {63'd0, error}, 64'd1);
        start_session();
        check("badidx_error_cleared", {63'd0, error}, 64'd0);
        send_byte(8'hFF);
        check("badidx_then_done", {63'd0, done}, 64'd1);
        end_session();

        // Zero-length region, block region, then session drop mid-DATA
        start_session();
        cur_q.delete();
        send_record(8'h00, cur_q);
        fill(2, 32'h0000_0201);
        send_record(8'h03, cur_q);
        push_exp(sys_pkg::STOR_BLOCK, 32'h0010_0000, 16'h0201, 2'b11);
        drain_and_compare("len0_blk");
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hA1);
        send_byte(8'hB2);
        push_exp(sys_pkg::STOR_SDR, 32'h0090_0000, 16'hB2A1, 2'b11);
        end_session();
        check("drop_data_error", {63'd0, error}, 64'd1);
        check("drop_data_done", {63'd0, done}, 64'd0);
        drain_and_compare("drop_data");

        // Session drop between records is a clean end without terminator
        start_session();
        fill(1, 32'h0000_005A);
        send_record(8'h04, cur_q);
        model_record(4, cur_q);
        end_session();
        tick(1);
        check("drop_idx_error", {63'd0, error}, 64'd0);
        check("drop_idx_done", {63'd0, done}, 64'd0);
        drain_and_compare("drop_idx");

        // Randomized record streams
        for (int s = 0; s < 3; s++) begin
            ack_delay = $urandom_range(0, 3);
            start_session();
            if (s == 0) begin
                fill_random(18);
                model_record(8, cur_q);
                send_record(8'h08, cur_q);
            end
            nrec = $urandom_range(1, 3);
            for (int r = 0; r < nrec; r++) begin
                idx = $urandom_range(0, 8);
                len = $urandom_range(0, 9);
                fill_random(len);
                model_record(idx, cur_q);
                send_record(8'(idx), cur_q);
            end
            send_byte(8'hFF);
            drain_and_compare($sformatf("rand%0d", s));
            check("rand_done", {63'd0, done}, 64'd1);
            check("rand_error", {63'd0, error}, 64'd0);
            end_session();
        end

        // Reset pulse while a write is pending
        ack_delay = 1000;
        start_session();
        fill(2, 32'h0000_3412);
        send_record(8'h01, cur_q);
        check("rstw_pre_req", {63'd0, wr_req}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstw_req", {63'd0, wr_req}, 64'd0);
        check("rstw_wait", {63'd0, dl_wait}, 64'd0);
        check("rstw_addr", {32'd0, wr_addr}, 64'd0);
        check("rstw_data", {48'd0, wr_data}, 64'd0);
        check("rstw_be", {62'd0, wr_be}, 64'd0);
        check("rstw_done", {63'd0, done}, 64'd0);
        check("rstw_error", {63'd0, error}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ack_delay = 1;
        tick(1);
        fill(2, 32'h0000_BBAA);
        send_record(8'h02, cur_q);
        tick(3);
        drain_and_compare("rstw_idle");
        start_session();
        fill(2, 32'h0000_ADDE);
        send_record(8'h03, cur_q);
        model_record(3, cur_q);
        send_byte(8'hFF);
        drain_and_compare("rstw_resume");
        check("rstw_resume_done", {63'd0, done}, 64'd1);
        end_session();

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
